// File: rtl/adc_frame_aligner.sv
// Frame aligner for deserialised ADC LVDS lanes: searches for frame lock by
// pulsing bitslip against FRAME_PAT, tracks lock health, and merges each
// channel's two data lanes into one RES-bit sample.
module adc_frame_aligner #(
  parameter int unsigned      N_CH      = 4,
  parameter int unsigned      SER_W     = 8,
  parameter int unsigned      RES       = 14,
  parameter logic [SER_W-1:0] FRAME_PAT = 8'hF0,
  parameter int unsigned      LOCK_CNT  = 4,
  parameter int unsigned      SLIP_WAIT = 3,
  parameter int unsigned      LOSS_CNT  = 3
) (
  input  logic                       CLKDIV,
  input  logic                       cpu_resetn,
  input  logic                       enable,
  input  logic [SER_W-1:0]           frm_data,
  input  logic [N_CH*SER_W-1:0]      lane_d0,
  input  logic [N_CH*SER_W-1:0]      lane_d1,
  input  logic                       err_clr,
  output logic                       bitslip,
  output logic                       aligned,
  output logic                       lock_lost,
  output logic                       search_fail,
  output logic [$clog2(SER_W)-1:0]   slip_cnt,
  output logic [N_CH*RES-1:0]        sample,
  output logic                       sample_valid
);

  localparam int unsigned SLIP_W  = $clog2(SER_W);
  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned LOSS_W  = $clog2(LOSS_CNT + 1);
  localparam int unsigned WAIT_W  = (SLIP_WAIT > 2) ? $clog2(SLIP_WAIT) : 1;
  localparam int unsigned TOT_MAX = 2 * SER_W;
  localparam int unsigned TOT_W   = $clog2(TOT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SLIP,
    ST_WAIT,
    ST_LOCKED
  } state_t;

  state_t              state;
  logic [MATCH_W-1:0]  match_cnt;
  logic [LOSS_W-1:0]   loss_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [TOT_W-1:0]    total_slip;
  logic [N_CH*RES-1:0] merged;
  logic                frm_match;
  logic                lane_unused;

  assign frm_match = (frm_data == FRAME_PAT);

  // Word bits above RES/2-1 carry no sample data.
  assign lane_unused = ^{lane_d0, lane_d1};

  // Alignment FSM with registered bitslip/aligned and sticky error flags.
  // The check cycle is the last of the SLIP_WAIT bitslip-free cycles, so
  // consecutive pulses during a search are SLIP_WAIT+1 cycles apart.
  always_ff @(posedge CLKDIV or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state       <= ST_IDLE;
      bitslip     <= 1'b0;
      aligned     <= 1'b0;
      lock_lost   <= 1'b0;
      search_fail <= 1'b0;
      slip_cnt    <= '0;
      match_cnt   <= '0;
      loss_cnt    <= '0;
      wait_cnt    <= '0;
      total_slip  <= '0;
    end else begin
      bitslip <= 1'b0;
      if (err_clr) begin
        lock_lost   <= 1'b0;
        search_fail <= 1'b0;
      end
      if (!enable) begin
        state   <= ST_IDLE;
        aligned <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state      <= ST_CHECK;
            slip_cnt   <= '0;
            total_slip <= '0;
            match_cnt  <= '0;
          end
          ST_CHECK: begin
            if (frm_match) begin
              if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                state     <= ST_LOCKED;
                aligned   <= 1'b1;
                match_cnt <= '0;
                loss_cnt  <= '0;
              end else begin
                match_cnt <= match_cnt + MATCH_W'(1);
              end
            end else begin
              state     <= ST_SLIP;
              bitslip   <= 1'b1;
              match_cnt <= '0;
              slip_cnt  <= (slip_cnt == SLIP_W'(SER_W - 1)) ? '0
                                                            : slip_cnt + SLIP_W'(1);
              if (total_slip != TOT_W'(TOT_MAX)) begin
                total_slip <= total_slip + TOT_W'(1);
              end
              if (total_slip == TOT_W'(TOT_MAX - 1)) begin
                search_fail <= 1'b1;
              end
            end
          end
          ST_SLIP: begin
            wait_cnt <= '0;
            state    <= (SLIP_WAIT > 1) ? ST_WAIT : ST_CHECK;
          end
          ST_WAIT: begin
            if (wait_cnt >= WAIT_W'(SLIP_WAIT - 2)) begin
              state <= ST_CHECK;
            end else begin
              wait_cnt <= wait_cnt + WAIT_W'(1);
            end
          end
          ST_LOCKED: begin
            if (frm_match) begin
              loss_cnt <= '0;
            end else if (loss_cnt == LOSS_W'(LOSS_CNT - 1)) begin
              state     <= ST_CHECK;
              aligned   <= 1'b0;
              lock_lost <= 1'b1;
              loss_cnt  <= '0;
              match_cnt <= '0;
            end else begin
              loss_cnt <= loss_cnt + LOSS_W'(1);
            end
          end
          default: begin
            state   <= ST_IDLE;
            aligned <= 1'b0;
          end
        endcase
      end
    end
  end

  // Lane merge: MSB-first interleave {d1[0], d0[0], d1[1], d0[1], ...}.
  always_comb begin
    merged = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      for (int unsigned i = 0; i < RES / 2; i++) begin
        merged[c*RES + RES - 1 - 2*i] = lane_d1[c*SER_W + i];
        merged[c*RES + RES - 2 - 2*i] = lane_d0[c*SER_W + i];
      end
    end
  end

  // Sample register; valid tracks the alignment state of the captured frame.
  always_ff @(posedge CLKDIV or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample       <= merged;
      sample_valid <= aligned & enable;
    end
  end

endmodule

// File: tb/tb_adc_frame_aligner.sv
// Self-checking bench for adc_frame_aligner: randomized lanes and frame words
// against a behavioural model of lock search, lock loss and lane merging.
module tb_adc_frame_aligner;

  localparam int unsigned      N_CH      = 4;
  localparam int unsigned      SER_W     = 8;
  localparam int unsigned      RES       = 14;
  localparam logic [SER_W-1:0] FRAME_PAT = 8'hF0;
  localparam int unsigned      LOCK_CNT  = 4;
  localparam int unsigned      SLIP_WAIT = 3;
  localparam int unsigned      LOSS_CNT  = 3;
  localparam int unsigned      SLIP_W    = $clog2(SER_W);

  logic                  CLKDIV;
  logic                  cpu_resetn;
  logic                  enable;
  logic [SER_W-1:0]      frm_data;
  logic [N_CH*SER_W-1:0] lane_d0;
  logic [N_CH*SER_W-1:0] lane_d1;
  logic                  err_clr;
  logic                  bitslip;
  logic                  aligned;
  logic                  lock_lost;
  logic                  search_fail;
  logic [SLIP_W-1:0]     slip_cnt;
  logic [N_CH*RES-1:0]   sample;
  logic                  sample_valid;

  int checks = 0;
  int errors = 0;
  int last_k = 0;

  adc_frame_aligner #(
    .N_CH(N_CH), .SER_W(SER_W), .RES(RES), .FRAME_PAT(FRAME_PAT),
    .LOCK_CNT(LOCK_CNT), .SLIP_WAIT(SLIP_WAIT), .LOSS_CNT(LOSS_CNT)
  ) dut (
    .CLKDIV(CLKDIV), .cpu_resetn(cpu_resetn), .enable(enable),
    .frm_data(frm_data), .lane_d0(lane_d0), .lane_d1(lane_d1),
    .err_clr(err_clr), .bitslip(bitslip), .aligned(aligned),
    .lock_lost(lock_lost), .search_fail(search_fail), .slip_cnt(slip_cnt),
    .sample(sample), .sample_valid(sample_valid)
  );

  initial begin
    CLKDIV = 1'b0;
    forever #5 CLKDIV = ~CLKDIV;
  end

  task automatic tick();
    @(posedge CLKDIV);
    #1;
  endtask

  // Frame word seen k bitslips away from alignment.
  function automatic logic [SER_W-1:0] rotl(input int unsigned k);
    logic [SER_W-1:0] p;
    p = FRAME_PAT;
    return (p << k) | (p >> (SER_W - k));
  endfunction

  function automatic logic [SER_W-1:0] bad_word();
    logic [SER_W-1:0] v;
    v = SER_W'($urandom);
    while (v == FRAME_PAT) v = SER_W'($urandom);
    return v;
  endfunction

  // Sample built by shifting in {d1[i], d0[i]} pairs, first pair ends at the MSB.
  function automatic logic [N_CH*RES-1:0] merge_model(input logic [N_CH*SER_W-1:0] d0,
                                                      input logic [N_CH*SER_W-1:0] d1);
    logic [N_CH*RES-1:0] s;
    logic [RES-1:0]      ch;
    logic [SER_W-1:0]    w0;
    logic [SER_W-1:0]    w1;
    s = '0;
    for (int c = 0; c < N_CH; c++) begin
      w0 = d0[c*SER_W +: SER_W];
      w1 = d1[c*SER_W +: SER_W];
      ch = '0;
      for (int i = 0; i < RES / 2; i++) ch = {ch[RES-3:0], w1[i], w0[i]};
      s[c*RES +: RES] = ch;
    end
    return s;
  endfunction

  task automatic rand_lanes();
    for (int c = 0; c < N_CH; c++) begin
      lane_d0[c*SER_W +: SER_W] = SER_W'($urandom);
      lane_d1[c*SER_W +: SER_W] = SER_W'($urandom);
    end
  endtask

  task automatic test_reset();
    logic [N_CH*SER_W-1:0] s0;
    logic [N_CH*SER_W-1:0] s1;
    cpu_resetn = 1'b0;
    enable     = 1'b1;
    err_clr    = 1'b1;
    frm_data   = SER_W'($urandom);
    rand_lanes();
    #23;
    checks++;
    if ({bitslip, aligned, lock_lost, search_fail, slip_cnt, sample_valid} !== '0) begin
      errors++;
      $display("FAIL reset_flags got bs=%0b al=%0b ll=%0b sf=%0b sc=%0d sv=%0b exp all 0",
               bitslip, aligned, lock_lost, search_fail, slip_cnt, sample_valid);
    end
    checks++;
    if (sample !== '0) begin
      errors++;
      $display("FAIL reset_sample got %h exp 0", sample);
    end
    enable  = 1'b0;
    err_clr = 1'b0;
    @(negedge CLKDIV);
    cpu_resetn = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      rand_lanes();
      frm_data = SER_W'($urandom);
      s0 = lane_d0;
      s1 = lane_d1;
      tick();
      checks++;
      if (bitslip !== 1'b0 || aligned !== 1'b0 || sample_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_quiet cyc=%0d got bs=%0b al=%0b sv=%0b exp 0 0 0",
                 cyc, bitslip, aligned, sample_valid);
      end
      checks++;
      if (sample !== merge_model(s0, s1)) begin
        errors++;
        $display("FAIL idle_sample cyc=%0d got %h exp %h", cyc, sample, merge_model(s0, s1));
      end
    end
  endtask

  task automatic test_direct_lock();
    logic exp_al;
    enable = 1'b0;
    tick();
    frm_data = FRAME_PAT;
    enable   = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      tick();
      exp_al = (cyc >= 1 + LOCK_CNT);
      checks++;
      if (aligned !== exp_al || bitslip !== 1'b0) begin
        errors++;
        $display("FAIL direct_lock cyc=%0d got al=%0b bs=%0b exp al=%0b bs=0",
                 cyc, aligned, bitslip, exp_al);
      end
    end
    checks++;
    if (slip_cnt !== '0) begin
      errors++;
      $display("FAIL direct_slip_cnt got %0d exp 0", slip_cnt);
    end
  endtask

  task automatic test_slip_search(input int unsigned k);
    int unsigned rot;
    int pulses;
    int last;
    int rise;
    enable = 1'b0;
    tick();
    rot      = k;
    frm_data = rotl(rot);
    enable   = 1'b1;
    pulses   = 0;
    last     = 0;
    rise     = -1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      tick();
      if (bitslip) begin
        pulses++;
        if (pulses > 1) begin
          checks++;
          if (cyc - last != int'(SLIP_WAIT + 1)) begin
            errors++;
            $display("FAIL slip_spacing k=%0d got %0d exp %0d", k, cyc - last, SLIP_WAIT + 1);
          end
        end
        last     = cyc;
        rot      = (rot + SER_W - 1) % SER_W;
        frm_data = rotl(rot);
      end
      if (aligned) begin
        rise = cyc;
        break;
      end
    end
    checks++;
    if (rise < 0 || pulses != int'(k)) begin
      errors++;
      $display("FAIL slip_search k=%0d got pulses=%0d rise=%0d exp pulses=%0d", k, pulses, rise, k);
    end
    checks++;
    if (rise - last != int'(SLIP_WAIT + LOCK_CNT)) begin
      errors++;
      $display("FAIL slip_lock_latency k=%0d got %0d exp %0d", k, rise - last, SLIP_WAIT + LOCK_CNT);
    end
    checks++;
    if (slip_cnt !== SLIP_W'(k)) begin
      errors++;
      $display("FAIL slip_cnt k=%0d got %0d exp %0d", k, slip_cnt, k);
    end
    last_k = int'(k);
  endtask

  task automatic test_lane_merge();
    logic [N_CH*SER_W-1:0] s0;
    logic [N_CH*SER_W-1:0] s1;
    logic [RES-1:0]        ch0;
    rand_lanes();
    lane_d1[SER_W-1:0] = 8'h01;
    lane_d0[SER_W-1:0] = 8'h00;
    tick();
    ch0 = sample[RES-1:0];
    checks++;
    if (ch0 !== 14'h2000 || sample_valid !== 1'b1) begin
      errors++;
      $display("FAIL merge_d1bit0 got %h sv=%0b exp 2000 sv=1", ch0, sample_valid);
    end
    lane_d1[SER_W-1:0] = 8'h00;
    lane_d0[SER_W-1:0] = 8'h40;
    tick();
    ch0 = sample[RES-1:0];
    checks++;
    if (ch0 !== 14'h0001 || sample_valid !== 1'b1) begin
      errors++;
      $display("FAIL merge_d0bit6 got %h sv=%0b exp 0001 sv=1", ch0, sample_valid);
    end
    for (int n = 0; n < 20; n++) begin
      rand_lanes();
      s0 = lane_d0;
      s1 = lane_d1;
      tick();
      checks++;
      if (sample !== merge_model(s0, s1) || sample_valid !== 1'b1) begin
        errors++;
        $display("FAIL merge_rand n=%0d got %h sv=%0b exp %h sv=1",
                 n, sample, sample_valid, merge_model(s0, s1));
      end
    end
  endtask

  task automatic test_lock_loss();
    frm_data = bad_word();
    tick();
    frm_data = bad_word();
    tick();
    frm_data = FRAME_PAT;
    tick();
    tick();
    checks++;
    if (aligned !== 1'b1 || lock_lost !== 1'b0) begin
      errors++;
      $display("FAIL loss_two_miss got al=%0b ll=%0b exp al=1 ll=0", aligned, lock_lost);
    end
    for (int m = 1; m <= int'(LOSS_CNT); m++) begin
      frm_data = bad_word();
      tick();
      checks++;
      if (aligned !== (m < int'(LOSS_CNT)) || lock_lost !== (m == int'(LOSS_CNT))) begin
        errors++;
        $display("FAIL loss_seq m=%0d got al=%0b ll=%0b exp al=%0b ll=%0b",
                 m, aligned, lock_lost, m < int'(LOSS_CNT), m == int'(LOSS_CNT));
      end
    end
    frm_data = bad_word();
    tick();
    checks++;
    if (bitslip !== 1'b1 || slip_cnt !== SLIP_W'((last_k + 1) % SER_W)) begin
      errors++;
      $display("FAIL loss_reslip got bs=%0b sc=%0d exp bs=1 sc=%0d",
               bitslip, slip_cnt, (last_k + 1) % SER_W);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (lock_lost !== 1'b0) begin
      errors++;
      $display("FAIL loss_clear got %0b exp 0", lock_lost);
    end
    enable = 1'b0;
    tick();
    frm_data = FRAME_PAT;
    enable   = 1'b1;
    repeat (1 + LOCK_CNT) tick();
    checks++;
    if (aligned !== 1'b1) begin
      errors++;
      $display("FAIL relock got %0b exp 1", aligned);
    end
    for (int m = 1; m <= int'(LOSS_CNT); m++) begin
      frm_data = bad_word();
      err_clr  = (m == int'(LOSS_CNT));
      tick();
    end
    err_clr = 1'b0;
    checks++;
    if (lock_lost !== 1'b1 || aligned !== 1'b0) begin
      errors++;
      $display("FAIL loss_set_wins got ll=%0b al=%0b exp ll=1 al=0", lock_lost, aligned);
    end
  endtask

  task automatic test_search_fail();
    int pulses;
    int last;
    int p16;
    enable  = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (search_fail !== 1'b0 || lock_lost !== 1'b0) begin
      errors++;
      $display("FAIL sf_pre_clear got sf=%0b ll=%0b exp 0 0", search_fail, lock_lost);
    end
    enable = 1'b1;
    pulses = 0;
    last   = 0;
    p16    = -10;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      frm_data = bad_word();
      tick();
      if (cyc == p16 + 1) begin
        checks++;
        if (search_fail !== 1'b1) begin
          errors++;
          $display("FAIL sf_after16 got %0b exp 1", search_fail);
        end
      end
      if (bitslip) begin
        pulses++;
        if (pulses > 1) begin
          checks++;
          if (cyc - last != int'(SLIP_WAIT + 1)) begin
            errors++;
            $display("FAIL sf_spacing pulse=%0d got %0d exp %0d", pulses, cyc - last, SLIP_WAIT + 1);
          end
        end
        last = cyc;
        if (pulses == int'(2 * SER_W - 1)) begin
          checks++;
          if (search_fail !== 1'b0) begin
            errors++;
            $display("FAIL sf_early got %0b exp 0", search_fail);
          end
        end
        if (pulses == int'(2 * SER_W)) p16 = cyc;
        if (pulses == int'(2 * SER_W + 4)) break;
      end
    end
    checks++;
    if (pulses != int'(2 * SER_W + 4) || search_fail !== 1'b1) begin
      errors++;
      $display("FAIL sf_continue got pulses=%0d sf=%0b exp pulses=%0d sf=1",
               pulses, search_fail, 2 * SER_W + 4);
    end
    repeat (SLIP_WAIT) begin
      frm_data = bad_word();
      tick();
    end
    enable = 1'b0;
    tick();
    checks++;
    if (bitslip !== 1'b0 || aligned !== 1'b0 || sample_valid !== 1'b0 || search_fail !== 1'b1) begin
      errors++;
      $display("FAIL sf_disable got bs=%0b al=%0b sv=%0b sf=%0b exp 0 0 0 1",
               bitslip, aligned, sample_valid, search_fail);
    end
    for (int cyc = 0; cyc < 8; cyc++) begin
      frm_data = bad_word();
      tick();
      checks++;
      if (bitslip !== 1'b0 || search_fail !== 1'b1) begin
        errors++;
        $display("FAIL sf_idle_hold cyc=%0d got bs=%0b sf=%0b exp bs=0 sf=1", cyc, bitslip, search_fail);
      end
    end
  endtask

  task automatic test_reset_midop();
    enable = 1'b1;
    repeat (6) begin
      frm_data = bad_word();
      tick();
    end
    #2;
    cpu_resetn = 1'b0;
    #1;
    checks++;
    if ({bitslip, aligned, lock_lost, search_fail, slip_cnt, sample_valid} !== '0 || sample !== '0) begin
      errors++;
      $display("FAIL midop_reset got bs=%0b al=%0b ll=%0b sf=%0b sc=%0d sv=%0b exp all 0",
               bitslip, aligned, lock_lost, search_fail, slip_cnt, sample_valid);
    end
    frm_data = FRAME_PAT;
    @(negedge CLKDIV);
    cpu_resetn = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      tick();
      checks++;
      if (bitslip !== 1'b0 || aligned !== (cyc >= int'(1 + LOCK_CNT))) begin
        errors++;
        $display("FAIL midop_release cyc=%0d got bs=%0b al=%0b exp bs=0 al=%0b",
                 cyc, bitslip, aligned, cyc >= int'(1 + LOCK_CNT));
      end
    end
  endtask

  initial begin
    cpu_resetn = 1'b0;
    enable     = 1'b0;
    err_clr    = 1'b0;
    frm_data   = '0;
    lane_d0    = '0;
    lane_d1    = '0;
    test_reset();
    test_direct_lock();
    test_slip_search(3);
    test_slip_search($urandom_range(1, SER_W - 1));
    test_lane_merge();
    test_lock_loss();
    test_search_fail();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_frame_aligner.md
Name: adc_frame_aligner

Overview:
- Parametrised successor to the fixed 4-channel LVDS capture path's bitslip and lane-merge stage.
- Operates in the divided-clock (CLKDIV) domain on already-deserialised ISERDES words.
- Searches for frame lock by pulsing bitslip against a programmable frame pattern and tracks lock health.
- Merges each channel's two data lanes into one RES-bit sample; N_CH channels in parallel.

Parameters:
- N_CH, 4, number of ADC channels (two lanes each, d0/d1), 1..8.
- SER_W, 8, ISERDES word width per lane.
- RES, 14, sample resolution; even, RES/2 <= SER_W.
- FRAME_PAT, 8'hF0, expected frame-clock word when aligned (SER_W bits).
- LOCK_CNT, 4, consecutive pattern matches required to declare lock.
- SLIP_WAIT, 3, idle cycles after each bitslip pulse before re-checking.
- LOSS_CNT, 3, consecutive mismatches while locked that declare lock loss.

Ports:
- CLKDIV  in  1  divided sample clock; all logic is on its rising edge.
- cpu_resetn  in  1  asynchronous active-low reset.
- enable  in  1  run alignment; low forces IDLE.
- frm_data  in  SER_W  deserialised frame-clock word.
- lane_d0  in  N_CH*SER_W  lane-0 words; channel c occupies [c*SER_W +: SER_W].
- lane_d1  in  N_CH*SER_W  lane-1 words, same packing as lane_d0.
- err_clr  in  1  single-cycle pulse; clears the sticky flags.
- bitslip  out  1  one-cycle pulse to every ISERDES.
- aligned  out  1  high while in LOCKED.
- lock_lost  out  1  sticky: lock was lost at least once.
- search_fail  out  1  sticky: 2*SER_W slips without reaching lock.
- slip_cnt  out  $clog2(SER_W)  slips since the last search start, modulo SER_W.
- sample  out  N_CH*RES  merged samples; channel c occupies [c*RES +: RES].
- sample_valid  out  1  sample is from an aligned frame.

Behaviour:
- Reset: every output is 0; FSM in IDLE; all counters 0.
- States:
  - IDLE: go to CHECK when enable=1. Entering CHECK from IDLE clears slip_cnt, the total-slip counter and the match counter.
  - CHECK:
    - If frm_data==FRAME_PAT, increment the match counter. When it reaches LOCK_CNT, go to LOCKED.
    - Otherwise clear the match counter and go to SLIP.
  - SLIP: bitslip=1 for exactly this one cycle; slip_cnt increments and wraps at SER_W; the total-slip counter increments. Go to WAIT.
  - WAIT: hold for SLIP_WAIT cycles with bitslip=0 and frm_data ignored, then go to CHECK.
  - LOCKED:
    - aligned=1.
    - A mismatch increments the loss counter; any match clears it.
    - When the loss counter reaches LOSS_CNT: set lock_lost, clear aligned, go to CHECK. slip_cnt is not cleared.
- Search failure: when the total-slip counter reaches 2*SER_W, set search_fail. The search continues and the total-slip counter saturates.
- Sticky flags:
  - Cleared only by err_clr or reset.
  - If err_clr coincides with a set event, the set wins.
- enable low in any state:
  - Next cycle the FSM is in IDLE, aligned=0 and sample_valid=0, and any pending bitslip is cancelled.
  - Sticky flags are held.
- Lane merge, per channel c, for i = 0..RES/2-1:
  - sample[c*RES + RES-1-2i] = d1_c[i]
  - sample[c*RES + RES-2-2i] = d0_c[i]
  - Equivalently MSB-first {d1[0], d0[0], d1[1], d0[1], ...}. Word bits above RES/2-1 are unused.
- Output timing:
  - sample is registered: 1-cycle latency from lane inputs.
  - sample_valid is aligned registered alongside it, so sample_valid and its sample are cycle-coincident.
  - sample updates every cycle regardless of alignment.
- Reset asserted mid-operation: asynchronous return to the reset values; no bitslip glitch after release.

Test Plan:
- Reset/idle: cpu_resetn=0 with random inputs -> all outputs 0. Release with enable=0 for 10 cycles -> bitslip never pulses.
- Direct lock: enable=1, frm_data=8'hF0 constant -> aligned rises 5 cycles after enable (IDLE→CHECK, then 4 matches); slip_cnt=0; no bitslip.
- Slip search: the model rotates frm_data one position per bitslip, starting 3 slips away from 8'hF0 -> exactly 3 bitslip pulses each spaced 4 cycles apart, then aligned; slip_cnt=3.
- Lane merge: N_CH=4, RES=14, aligned, d1_0=8'h01, d0_0=8'h00 (bit0 of d1 set) -> sample[13:0]=14'h2000 one cycle later with sample_valid=1. d0_0=8'h40 (bit6) -> sample[13:0]=14'h0001.
- Lock loss:
  - While locked, 2 mismatches then 1 match -> remains aligned.
  - 3 consecutive mismatches -> aligned=0 on the next cycle, lock_lost=1, FSM slips again.
  - err_clr pulse -> lock_lost=0.
- Search failure:
  - frm_data never matches -> search_fail=1 after the 16th bitslip; bitslip continues every 4 cycles.
  - Drop enable -> IDLE within 1 cycle, search_fail held.
